// File: rtl/ultrasonic_echo_responder.sv
// rtl/ultrasonic_echo_responder.sv - ultrasonic ranging sensor emulator: trig in, distance-scaled echo out
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   trig         trigger from the sensor initiator, asynchronous to clk
//   distance_cm  emulated target distance in cm, 0 = no object
//   echo         registered echo pulse, width proportional to distance
//   busy         high whenever a measurement is in progress (state != IDLE)
//   trig_err     one-cycle pulse when a too-short trig pulse is rejected
//
// Optional feature: define ULTRASONIC_ECHO_JITTER_EN to add 0..15 extra echo
// cycles per measurement from a 16-bit Fibonacci LFSR (seed 0xACE1).

module ultrasonic_echo_responder #(
  parameter int MIN_TRIG_CYCLES    = 500,
  parameter int BURST_DELAY_CYCLES = 100,
  parameter int CYCLES_PER_CM      = 2915,
  parameter int NO_OBJ_CYCLES      = 1900000,
  parameter int HOLDOFF_CYCLES     = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [7:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    DELAY,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        trig_m;
  logic        trig_s;
  logic        trig_d;
  // fill_s marks trig_s as holding a real sample rather than its reset value;
  // armed is set once trig_s has truly been seen low, so a trig level held
  // high across reset release cannot masquerade as a rising edge.
  logic        fill_m;
  logic        fill_s;
  logic        armed;

  logic [15:0] trig_cnt;
  logic [23:0] cnt;
  logic [23:0] echo_len;
  logic [7:0]  dist_q;
  logic [23:0] base_len;

  logic        err_set;
  logic        latch_en;
  logic        echo_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
      fill_m <= 1'b0;
      fill_s <= 1'b0;
      armed  <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_d <= trig_s;
      fill_m <= 1'b1;
      fill_s <= fill_m;
      armed  <= armed | (fill_s & ~trig_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    latch_en   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && trig_s && !trig_d) next_state = TRIG_HIGH;
      end
      TRIG_HIGH: begin
        if (!trig_s) begin
          if (trig_cnt >= 16'(MIN_TRIG_CYCLES)) begin
            next_state = DELAY;
            latch_en   = 1'b1;
          end else begin
            next_state = IDLE;
            err_set    = 1'b1;
          end
        end
      end
      DELAY: begin
        if ((cnt + 24'd1) >= 24'(BURST_DELAY_CYCLES)) next_state = ECHO;
      end
      ECHO: begin
        if ((cnt + 24'd1) >= echo_len) next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if ((cnt + 24'd1) >= 24'(HOLDOFF_CYCLES)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign echo_start = (state == DELAY) && (next_state == ECHO);
  assign base_len   = (dist_q == 8'd0) ? 24'(NO_OBJ_CYCLES)
                                       : 24'(dist_q) * 24'(CYCLES_PER_CM);

`ifdef ULTRASONIC_ECHO_JITTER_EN
  logic [15:0] lfsr;

  // Current LFSR value supplies the jitter, then it steps once per ECHO entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             lfsr <= 16'hACE1;
    else if (echo_start) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             echo_len <= 24'd0;
    else if (echo_start) echo_len <= base_len + {20'd0, lfsr[3:0]};
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             echo_len <= 24'd0;
    else if (echo_start) echo_len <= base_len;
  end
`endif

  // cnt restarts from zero on every state change and measures time-in-state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 24'd0;
      trig_cnt <= 16'd0;
      dist_q   <= 8'd0;
      echo     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      cnt      <= (next_state != state) ? 24'd0 : cnt + 24'd1;
      echo     <= (next_state == ECHO);
      trig_err <= err_set;
      if (latch_en) dist_q <= distance_cm;
      if (state == IDLE && next_state == TRIG_HIGH)
        trig_cnt <= 16'd1;
      else if (state == TRIG_HIGH && trig_s && trig_cnt != 16'hFFFF)
        trig_cnt <= trig_cnt + 16'd1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// tb/tb_ultrasonic_echo_responder.sv - directed self-checking bench for ultrasonic_echo_responder

module tb_ultrasonic_echo_responder;

  localparam int MIN_T   = 10;
  localparam int BURST   = 8;
  localparam int CPC     = 4;
  localparam int NO_OBJ  = 1000;
  localparam int HOLD    = 20;
  // trig input fall -> echo rise: two synchroniser stages, one decision cycle, then DELAY
  localparam int GAP_EXP = 2 + 1 + BURST;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [7:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int overlap = 0;
  logic [15:0] model_lfsr = 16'hACE1;

  ultrasonic_echo_responder #(
    .MIN_TRIG_CYCLES(MIN_T),
    .BURST_DELAY_CYCLES(BURST),
    .CYCLES_PER_CM(CPC),
    .NO_OBJ_CYCLES(NO_OBJ),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trig(trig),
    .distance_cm(distance_cm),
    .echo(echo),
    .busy(busy),
    .trig_err(trig_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trig_err === 1'b1) err_pulses++;
    if (trig_err === 1'b1 && echo === 1'b1) overlap++;
  end

  task automatic exp_width(input int base, output int w);
`ifdef ULTRASONIC_ECHO_JITTER_EN
    w = base + int'(model_lfsr[3:0]);
    model_lfsr = {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
`else
    w = base;
`endif
  endtask

  task automatic run_trig(input int hi, input logic [7:0] d);
    distance_cm = d;
    @(negedge clk);
    trig = 1'b1;
    repeat (hi) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic measure(output int gap, output int w, output int h);
    gap = 0;
    while (echo !== 1'b1 && gap < 3000) begin
      @(negedge clk);
      gap++;
    end
    w = 0;
    while (echo === 1'b1 && w < 3000) begin
      w++;
      @(negedge clk);
    end
    h = 0;
    while (busy === 1'b1 && h < 3000) begin
      h++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig = 1'b0;
    distance_cm = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b expected 0", echo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (trig_err !== 1'b0) begin errors++; $display("FAIL reset_trig_err: got %b expected 0", trig_err); end
    rst = 1'b0;
    model_lfsr = 16'hACE1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int gap, w, h, ew, e0;
    e0 = err_pulses;
    run_trig(12, 8'd25);
    exp_width(100, ew);
    measure(gap, w, h);
    checks++; if (gap !== GAP_EXP) begin errors++; $display("FAIL basic_gap: got %0d expected %0d", gap, GAP_EXP); end
    checks++; if (w !== ew) begin errors++; $display("FAIL basic_width: got %0d expected %0d", w, ew); end
    checks++; if (h !== HOLD) begin errors++; $display("FAIL basic_holdoff: got %0d expected %0d", h, HOLD); end
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL basic_no_err: got %0d pulses expected 0", err_pulses - e0); end
  endtask

  task automatic test_short_trig();
    int gap, w, h, ew, e0, echo_seen;
    e0 = err_pulses;
    echo_seen = 0;
    run_trig(5, 8'd25);
    repeat (40) begin
      @(negedge clk);
      if (echo === 1'b1) echo_seen++;
    end
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL short_err_pulse: got %0d cycles expected 1", err_pulses - e0); end
    checks++; if (echo_seen !== 0) begin errors++; $display("FAIL short_no_echo: got %0d echo cycles expected 0", echo_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b expected 0", busy); end
    run_trig(12, 8'd25);
    exp_width(100, ew);
    measure(gap, w, h);
    checks++; if (w !== ew) begin errors++; $display("FAIL short_recover_width: got %0d expected %0d", w, ew); end
  endtask

  task automatic test_no_object();
    int gap, w, h, ew;
    run_trig(12, 8'd0);
    exp_width(NO_OBJ, ew);
    measure(gap, w, h);
    checks++; if (w !== ew) begin errors++; $display("FAIL no_object_width: got %0d expected %0d", w, ew); end
  endtask

  task automatic test_ignore_during_echo();
    int gap, w, h, ew, e0;
    e0 = err_pulses;
    run_trig(12, 8'd25);
    exp_width(100, ew);
    gap = 0;
    while (echo !== 1'b1 && gap < 3000) begin
      @(negedge clk);
      gap++;
    end
    w = 0;
    while (echo === 1'b1 && w < 3000) begin
      w++;
      if (w == 10) distance_cm = 8'd200;
      trig = ((w >= 20 && w < 25) || (w >= 40 && w < 55));
      @(negedge clk);
    end
    h = 0;
    while (busy === 1'b1 && h < 3000) begin
      h++;
      trig = (h >= 3 && h < 8);
      @(negedge clk);
    end
    trig = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (w !== ew) begin errors++; $display("FAIL ignore_width: got %0d expected %0d", w, ew); end
    checks++; if (h !== HOLD) begin errors++; $display("FAIL ignore_holdoff: got %0d expected %0d", h, HOLD); end
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL ignore_no_err: got %0d pulses expected 0", err_pulses - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_echo();
    int gap, w, h, ew, busy_seen;
    run_trig(12, 8'd25);
    gap = 0;
    while (echo !== 1'b1 && gap < 3000) begin
      @(negedge clk);
      gap++;
    end
    repeat (50) @(negedge clk);
    trig = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo: got %b expected 0", echo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    model_lfsr = 16'hACE1;
    @(negedge clk);
    rst = 1'b0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL rst_held_trig: got %0d busy cycles expected 0", busy_seen); end
    trig = 1'b0;
    repeat (3) @(negedge clk);
    run_trig(12, 8'd25);
    exp_width(100, ew);
    measure(gap, w, h);
    checks++; if (w !== ew) begin errors++; $display("FAIL rst_fresh_width: got %0d expected %0d", w, ew); end
  endtask

  task automatic test_back_to_back();
    int gap, w, h, ew;
    for (int i = 0; i < 3; i++) begin
      run_trig(12, 8'd10);
      exp_width(40, ew);
      measure(gap, w, h);
      checks++; if (w !== ew) begin errors++; $display("FAIL b2b_width_%0d: got %0d expected %0d", i, w, ew); end
      checks++; if (w < 40 || w > 55) begin errors++; $display("FAIL b2b_range_%0d: got %0d expected 40..55", i, w); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_trig();
    test_no_object();
    test_ignore_during_echo();
    test_reset_mid_echo();
    test_back_to_back();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL err_echo_overlap: got %0d cycles expected 0", overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
